// File: rtl/stdp_weight_update.sv
// STDP weight update: converts a signed spike-time difference into a shift-based
// exponential delta and applies it to a saturating weight file. Optional periodic decay via STDP_DECAY_EN.
module stdp_weight_update #(
  parameter int NUM_PRE      = 4,
  parameter int W_BITS       = 4,
  parameter int W_INIT       = 8,
  parameter int A_MAX        = 4,
  parameter int TAU_SHIFT    = 2,
  parameter int WINDOW       = 20,
  parameter int DECAY_PERIOD = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         td_valid,
  output logic                         td_ready,
  input  logic [$clog2(NUM_PRE)-1:0]   td_idx,
  input  logic [7:0]                   td_value,
  output logic [NUM_PRE*W_BITS-1:0]    weights,
  output logic                         weight_upd,
  output logic [$clog2(NUM_PRE)-1:0]   upd_idx
);

  localparam int IDX_W = $clog2(NUM_PRE);
  localparam logic [W_BITS-1:0] W_INIT_V = W_BITS'(W_INIT);
  localparam logic [W_BITS-1:0] A_MAX_V  = W_BITS'(A_MAX);
  localparam logic [W_BITS:0]   WMAX_X   = {1'b0, {W_BITS{1'b1}}};
  localparam logic [8:0]        WIN_V    = 9'(WINDOW);
  localparam logic [8:0]        WB_V     = 9'(W_BITS);

`ifdef STDP_DECAY_EN
  typedef enum logic [1:0] {IDLE, CALC, APPLY, DECAY} state_t;
  localparam int CNT_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECAY_PERIOD - 1);
`else
  typedef enum logic [1:0] {IDLE, CALC, APPLY} state_t;
`endif

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        td_q, td_d;
  logic              ltp_q, ltp_d;
  logic [W_BITS-1:0] delta_q, delta_d;
  logic [W_BITS-1:0] w_q [NUM_PRE];
  logic [W_BITS-1:0] w_d [NUM_PRE];
  logic              weight_upd_q, weight_upd_d;
  logic [IDX_W-1:0]  upd_idx_q, upd_idx_d;
  logic              decay_pending;

  logic [8:0]        mag;
  logic [8:0]        k;
  logic [W_BITS-1:0] delta_calc;
  logic [W_BITS-1:0] old_w;
  logic [W_BITS-1:0] new_w;
  logic [W_BITS:0]   sum_w;

`ifdef STDP_DECAY_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              any_dec;
  assign decay_pending = pend_q;
`else
  assign decay_pending = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a pending decay pre-empts a waiting transaction in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef STDP_DECAY_EN
        if (decay_pending)                state_d = DECAY;
        else if (td_valid && td_ready)    state_d = CALC;
`else
        if (td_valid && td_ready)         state_d = CALC;
`endif
      end
      CALC:    state_d = APPLY;
      APPLY:   state_d = IDLE;
`ifdef STDP_DECAY_EN
      DECAY:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    td_ready   = (state_q == IDLE) && !rst && !decay_pending;
    weight_upd = weight_upd_q;
    upd_idx    = upd_idx_q;
    weights    = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++)
      weights[i*W_BITS +: W_BITS] = w_q[i];
  end

  // Delta: 9-bit magnitude so that -128 maps to +128 instead of wrapping
  always_comb begin
    mag = td_q[7] ? (9'd0 - {td_q[7], td_q}) : {1'b0, td_q};
    k   = mag >> TAU_SHIFT;
    if (mag == 9'd0 || mag > WIN_V || k >= WB_V) delta_calc = '0;
    else                                         delta_calc = A_MAX_V >> k;
  end

  // Saturating apply of the registered delta to the addressed weight
  always_comb begin
    old_w = w_q[idx_q];
    sum_w = {1'b0, old_w} + {1'b0, delta_q};
    if (ltp_q) new_w = (sum_w > WMAX_X) ? WMAX_X[W_BITS-1:0] : sum_w[W_BITS-1:0];
    else       new_w = (old_w >= delta_q) ? (old_w - delta_q) : '0;
  end

  always_comb begin
    idx_d        = idx_q;
    td_d         = td_q;
    ltp_d        = ltp_q;
    delta_d      = delta_q;
    upd_idx_d    = upd_idx_q;
    weight_upd_d = 1'b0;
    for (int unsigned i = 0; i < NUM_PRE; i++) w_d[i] = w_q[i];
`ifdef STDP_DECAY_EN
    any_dec = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (td_valid && td_ready) begin
          idx_d = td_idx;
          td_d  = td_value;
        end
      end
      CALC: begin
        ltp_d   = ~td_q[7];
        delta_d = delta_calc;
      end
      APPLY: begin
        w_d[idx_q]   = new_w;
        weight_upd_d = (new_w != old_w);
        upd_idx_d    = idx_q;
      end
`ifdef STDP_DECAY_EN
      DECAY: begin
        for (int unsigned i = 0; i < NUM_PRE; i++) begin
          if (w_q[i] != '0) begin
            w_d[i]  = w_q[i] - 1'b1;
            any_dec = 1'b1;
          end
        end
        weight_upd_d = any_dec;
        upd_idx_d    = '0;
      end
`endif
      default: ;
    endcase
  end

`ifdef STDP_DECAY_EN
  // A wrap during a transaction just stays pending until the FSM returns to IDLE
  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    pend_d = pend_q;
    if (state_q == DECAY) pend_d = 1'b0;
    if (cnt_q == CNT_MAX) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      td_q         <= '0;
      ltp_q        <= 1'b0;
      delta_q      <= '0;
      weight_upd_q <= 1'b0;
      upd_idx_q    <= '0;
      for (int unsigned i = 0; i < NUM_PRE; i++) w_q[i] <= W_INIT_V;
    end else begin
      idx_q        <= idx_d;
      td_q         <= td_d;
      ltp_q        <= ltp_d;
      delta_q      <= delta_d;
      weight_upd_q <= weight_upd_d;
      upd_idx_q    <= upd_idx_d;
      for (int unsigned i = 0; i < NUM_PRE; i++) w_q[i] <= w_d[i];
    end
  end

endmodule
